// File: rtl/ttl_byte_serializer_if.sv
// Parallel word handshake between an upstream latch bank and the serializer.
interface ttl_byte_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_ready;

    modport master (output d, output d_valid, input d_ready);
    modport slave  (input d, input d_valid, output d_ready);
endinterface

// File: rtl/ttl_byte_serializer.sv
// Holding-register fed parallel-to-serial shifter with TTL-style output delays.
// Define TTL_SER_DELAY_EN to drive the outputs through #(DELAY_RISE, DELAY_FALL) assigns.
module ttl_byte_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DELAY_RISE = 12,
    parameter int unsigned DELAY_FALL = 13
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ce_i,
    input  logic                     flip_i,
    ttl_byte_serializer_if.slave     bus,
    output logic                     q_o,
    output logic                     load_pulse_o,
    output logic [$clog2(WIDTH)-1:0] bit_cnt_o,
    output logic                     active_o,
    output logic                     underrun_o
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 16 || DELAY_RISE > 1000 || DELAY_FALL > 1000) begin : g_param_err
        $error("ttl_byte_serializer: parameter out of range");
    end

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic              dir_q, dir_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              load_pulse_q, load_pulse_d;
    logic              underrun_q, underrun_d;

    logic accept, at_last, load_evt, shift_evt, underrun_evt;
    logic q_w, d_ready_w, active_w;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            sr_q         <= '0;
            dir_q        <= 1'b0;
            cnt_q        <= '0;
            load_pulse_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            sr_q         <= sr_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            load_pulse_q <= load_pulse_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        accept       = bus.d_valid && !hold_full_q;
        at_last      = (state_q == StShift) && (cnt_q == LastCnt);
        // A load needs a full holding register, so it never coincides with an accept.
        load_evt     = ce_i && hold_full_q && ((state_q == StIdle) || at_last);
        shift_evt    = ce_i && (state_q == StShift) && (cnt_q != LastCnt);
        underrun_evt = ce_i && at_last && !hold_full_q;

        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        sr_d         = sr_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        load_pulse_d = load_evt;
        underrun_d   = underrun_evt;

        if (accept) begin
            hold_d      = bus.d;
            hold_full_d = 1'b1;
        end

        if (load_evt) begin
            sr_d        = hold_q;
            dir_d       = flip_i;
            hold_full_d = 1'b0;
            cnt_d       = '0;
            state_d     = StShift;
        end else if (shift_evt) begin
            sr_d  = dir_q ? (sr_q >> 1) : (sr_q << 1);
            cnt_d = cnt_q + 1'b1;
        end else if (underrun_evt) begin
            cnt_d   = '0;
            state_d = StIdle;
        end
    end

    always_comb begin
        active_w  = (state_q == StShift);
        q_w       = 1'b0;
        if (active_w) begin
            q_w = dir_q ? sr_q[0] : sr_q[WIDTH-1];
        end
        d_ready_w = !hold_full_q && !rst_i;
    end

    assign bit_cnt_o = cnt_q;

`ifdef TTL_SER_DELAY_EN
    assign #(DELAY_RISE, DELAY_FALL) q_o          = q_w;
    assign #(DELAY_RISE, DELAY_FALL) bus.d_ready  = d_ready_w;
    assign #(DELAY_RISE, DELAY_FALL) load_pulse_o = load_pulse_q;
    assign #(DELAY_RISE, DELAY_FALL) active_o     = active_w;
    assign #(DELAY_RISE, DELAY_FALL) underrun_o   = underrun_q;
`else
    assign q_o          = q_w;
    assign bus.d_ready  = d_ready_w;
    assign load_pulse_o = load_pulse_q;
    assign active_o     = active_w;
    assign underrun_o   = underrun_q;
`endif

endmodule

// File: tb/tb_ttl_byte_serializer.sv
// Directed self-checking bench for ttl_byte_serializer (WIDTH=8).
module tb_ttl_byte_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       flip = 1'b0;
    logic       q, load_pulse, active, underrun;
    logic [2:0] bit_cnt;
    int         passed = 0;
    int         total = 0;

    ttl_byte_serializer_if #(.WIDTH(8)) bus ();

    ttl_byte_serializer #(.WIDTH(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ce_i         (ce),
        .flip_i       (flip),
        .bus          (bus),
        .q_o          (q),
        .load_pulse_o (load_pulse),
        .bit_cnt_o    (bit_cnt),
        .active_o     (active),
        .underrun_o   (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.d = 8'h00;
        bus.d_valid = 1'b0;
        #3;
        total++; if (q !== 1'b0) $display("FAIL rst_q: got %b want 0", q); else passed++;
        total++; if (active !== 1'b0) $display("FAIL rst_active: got %b want 0", active); else passed++;
        total++; if (load_pulse !== 1'b0) $display("FAIL rst_load: got %b want 0", load_pulse); else passed++;
        total++; if (underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", underrun); else passed++;
        total++; if (bit_cnt !== 3'd0) $display("FAIL rst_cnt: got %0d want 0", bit_cnt); else passed++;
        total++; if (bus.d_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.d_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.d_ready !== 1'b1) $display("FAIL rel_ready: got %b want 1", bus.d_ready); else passed++;
        step();
        total++; if (active !== 1'b0) $display("FAIL rel_active: got %b want 0", active); else passed++;
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        w = 8'hA5;
        flip = 1'b0; ce = 1'b1; bus.d = w; bus.d_valid = 1'b1;
        step();
        total++; if (bus.d_ready !== 1'b0) $display("FAIL msb_ready: got %b want 0", bus.d_ready); else passed++;
        total++; if (active !== 1'b0) $display("FAIL msb_pre_active: got %b want 0", active); else passed++;
        bus.d_valid = 1'b0;
        step();
        total++; if (load_pulse !== 1'b1) $display("FAIL msb_load: got %b want 1", load_pulse); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++; if (q !== w[7-i]) $display("FAIL msb_q%0d: got %b want %b", i, q, w[7-i]); else passed++;
            total++; if (bit_cnt !== 3'(i)) $display("FAIL msb_cnt%0d: got %0d want %0d", i, bit_cnt, i); else passed++;
            total++; if (active !== 1'b1) $display("FAIL msb_active%0d: got %b want 1", i, active); else passed++;
            if (i == 1) begin
                total++; if (load_pulse !== 1'b0) $display("FAIL msb_load_len: got %b want 0", load_pulse); else passed++;
            end
            if (i < 7) step();
        end
        step();
        total++; if (underrun !== 1'b1) $display("FAIL msb_underrun: got %b want 1", underrun); else passed++;
        total++; if (active !== 1'b0) $display("FAIL msb_end_active: got %b want 0", active); else passed++;
        total++; if (q !== 1'b0) $display("FAIL msb_end_q: got %b want 0", q); else passed++;
        total++; if (bit_cnt !== 3'd0) $display("FAIL msb_end_cnt: got %0d want 0", bit_cnt); else passed++;
        step();
        total++; if (underrun !== 1'b0) $display("FAIL msb_underrun_len: got %b want 0", underrun); else passed++;
    endtask

    task automatic test_flip();
        logic [7:0] words [2];
        logic [7:0] w;
        words[0] = 8'h01;
        words[1] = 8'hC1;
        ce = 1'b1;
        for (int k = 0; k < 2; k++) begin
            w = words[k];
            flip = 1'b1; bus.d = w; bus.d_valid = 1'b1;
            step();
            bus.d_valid = 1'b0;
            step();
            flip = 1'b0;
            for (int i = 0; i < 8; i++) begin
                total++; if (q !== w[i]) $display("FAIL flip_w%0d_q%0d: got %b want %b", k, i, q, w[i]); else passed++;
                if (i < 7) step();
            end
            step();
            total++; if (underrun !== 1'b1) $display("FAIL flip_w%0d_underrun: got %b want 1", k, underrun); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        logic        exp_ready;
        stream = 16'hF00F;
        flip = 1'b0; ce = 1'b1; bus.d = 8'hF0; bus.d_valid = 1'b1;
        step();
        bus.d = 8'h0F;
        step();
        for (int k = 0; k < 16; k++) begin
            exp_ready = (k == 0) || (k >= 8);
            total++; if (q !== stream[15-k]) $display("FAIL b2b_q%0d: got %b want %b", k, q, stream[15-k]); else passed++;
            total++; if (underrun !== 1'b0) $display("FAIL b2b_underrun%0d: got %b want 0", k, underrun); else passed++;
            total++; if (bus.d_ready !== exp_ready) $display("FAIL b2b_ready%0d: got %b want %b", k, bus.d_ready, exp_ready); else passed++;
            if (k == 0 || k == 8) begin
                total++; if (load_pulse !== 1'b1) $display("FAIL b2b_load%0d: got %b want 1", k, load_pulse); else passed++;
            end
            if (k == 1) bus.d_valid = 1'b0;
            if (k < 15) step();
        end
        step();
        total++; if (underrun !== 1'b1) $display("FAIL b2b_end_underrun: got %b want 1", underrun); else passed++;
    endtask

    task automatic test_ce_toggle();
        logic exp_q;
        flip = 1'b0; ce = 1'b0; bus.d = 8'h80; bus.d_valid = 1'b1;
        step();
        bus.d_valid = 1'b0;
        total++; if (active !== 1'b0) $display("FAIL ce_noload: got %b want 0", active); else passed++;
        for (int i = 0; i < 8; i++) begin
            exp_q = (i == 0);
            ce = 1'b1;
            step();
            total++; if (q !== exp_q) $display("FAIL ce_q%0d_a: got %b want %b", i, q, exp_q); else passed++;
            total++; if (bit_cnt !== 3'(i)) $display("FAIL ce_cnt%0d_a: got %0d want %0d", i, bit_cnt, i); else passed++;
            if (i == 0) begin
                total++; if (load_pulse !== 1'b1) $display("FAIL ce_load: got %b want 1", load_pulse); else passed++;
            end
            ce = 1'b0;
            step();
            total++; if (q !== exp_q) $display("FAIL ce_q%0d_b: got %b want %b", i, q, exp_q); else passed++;
            total++; if (bit_cnt !== 3'(i)) $display("FAIL ce_cnt%0d_b: got %0d want %0d", i, bit_cnt, i); else passed++;
            if (i == 0) begin
                total++; if (load_pulse !== 1'b0) $display("FAIL ce_load_len: got %b want 0", load_pulse); else passed++;
            end
        end
        total++; if (active !== 1'b1) $display("FAIL ce_hold_active: got %b want 1", active); else passed++;
        ce = 1'b1;
        step();
        total++; if (underrun !== 1'b1) $display("FAIL ce_underrun: got %b want 1", underrun); else passed++;
    endtask

    task automatic test_reset_mid_word();
        flip = 1'b0; ce = 1'b1; bus.d = 8'hFF; bus.d_valid = 1'b1;
        step();
        bus.d = 8'h55;
        step();
        step();
        bus.d_valid = 1'b0;
        step();
        step();
        total++; if (bit_cnt !== 3'd3) $display("FAIL mid_cnt: got %0d want 3", bit_cnt); else passed++;
        total++; if (bus.d_ready !== 1'b0) $display("FAIL mid_held: got %b want 0", bus.d_ready); else passed++;
        total++; if (q !== 1'b1) $display("FAIL mid_q: got %b want 1", q); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (active !== 1'b0) $display("FAIL mid_rst_active: got %b want 0", active); else passed++;
        total++; if (q !== 1'b0) $display("FAIL mid_rst_q: got %b want 0", q); else passed++;
        total++; if (bit_cnt !== 3'd0) $display("FAIL mid_rst_cnt: got %0d want 0", bit_cnt); else passed++;
        total++; if (bus.d_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", bus.d_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        step();
        total++; if (bus.d_ready !== 1'b1) $display("FAIL mid_rel_ready: got %b want 1", bus.d_ready); else passed++;
        total++; if (active !== 1'b0) $display("FAIL mid_rel_active: got %b want 0", active); else passed++;
        step();
        total++; if (active !== 1'b0) $display("FAIL mid_noreplay: got %b want 0", active); else passed++;
        total++; if (load_pulse !== 1'b0) $display("FAIL mid_noload: got %b want 0", load_pulse); else passed++;
    endtask

    task automatic test_hold_full();
        logic [7:0] w;
        w = 8'h3C;
        flip = 1'b0; ce = 1'b0; bus.d = w; bus.d_valid = 1'b1;
        step();
        bus.d = 8'hC3;
        step();
        total++; if (bus.d_ready !== 1'b0) $display("FAIL hf_ready: got %b want 0", bus.d_ready); else passed++;
        step();
        bus.d_valid = 1'b0;
        ce = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            total++; if (q !== w[7-i]) $display("FAIL hf_q%0d: got %b want %b", i, q, w[7-i]); else passed++;
            if (i < 7) step();
        end
        step();
        total++; if (underrun !== 1'b1) $display("FAIL hf_underrun: got %b want 1", underrun); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_msb_first();
        test_flip();
        test_back_to_back();
        test_ce_toggle();
        test_reset_mid_word();
        test_hold_full();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
